backend_row_policy_predictor: RTL and testbench



---
 rtl/backend_policy_pkg.sv | 26 ++
 rtl/backend_row_policy_predictor_if.sv | 45 ++++
 rtl/bank_row_tracker.sv | 58 +++++
 rtl/backend_row_policy_predictor.sv | 135 +++++++++++++
 tb/tb_backend_row_policy_predictor.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/backend_policy_pkg.sv
// Shared types for the backend row-policy predictor: policy modes, data types and helpers.
package backend_policy_pkg;

  localparam int unsigned PolicyBits = 2;
  localparam int unsigned DtypeBits  = 2;

  typedef enum logic [PolicyBits-1:0] {
    ModeOpen     = 2'd0,
    ModeClose    = 2'd1,
    ModeLastCol  = 2'd2,
    ModeAdaptive = 2'd3
  } policy_mode_e;

  typedef enum logic [DtypeBits-1:0] {
    DtInstr  = 2'd0,
    DtWeight = 2'd1,
    DtKv     = 2'd2,
    DtOther  = 2'd3
  } data_type_e;

  // Streaming data (KV-cache, other) lets the locality counter close rows early.
  function automatic logic dtype_is_adaptive(data_type_e dt);
    return (dt == DtKv) || (dt == DtOther);
  endfunction

endpackage

// File: rtl/backend_row_policy_predictor_if.sv
// Frontend command, Ctrl command and statistics signals of the row-policy predictor.
interface backend_row_policy_predictor_if #(
  parameter int unsigned NUM_BANKS = 8,
  parameter int unsigned ROW_BITS  = 16,
  parameter int unsigned COL_BITS  = 4,
  parameter int unsigned STAT_BITS = 16
);
  localparam int unsigned BankBits = $clog2(NUM_BANKS);

  logic [1:0]           i_policy_mode;
  logic                 i_cmd_valid;
  logic                 o_cmd_ready;
  logic                 i_cmd_op;
  logic [BankBits-1:0]  i_cmd_bank;
  logic [ROW_BITS-1:0]  i_cmd_row;
  logic [COL_BITS-1:0]  i_cmd_col;
  logic [1:0]           i_cmd_dtype;
  logic                 o_cmd_valid;
  logic                 i_ctrl_ready;
  logic                 o_cmd_r_w;
  logic [BankBits-1:0]  o_cmd_bank;
  logic [ROW_BITS-1:0]  o_cmd_row;
  logic [COL_BITS-1:0]  o_cmd_col;
  logic                 o_cmd_auto_precharge;
  logic [STAT_BITS-1:0] o_stat_hit;
  logic [STAT_BITS-1:0] o_stat_conflict;
  logic [STAT_BITS-1:0] o_stat_closed;

  // Frontend scheduler and Ctrl side.
  modport master (
    output i_policy_mode, i_cmd_valid, i_cmd_op, i_cmd_bank, i_cmd_row, i_cmd_col,
           i_cmd_dtype, i_ctrl_ready,
    input  o_cmd_ready, o_cmd_valid, o_cmd_r_w, o_cmd_bank, o_cmd_row, o_cmd_col,
           o_cmd_auto_precharge, o_stat_hit, o_stat_conflict, o_stat_closed
  );

  // Predictor side.
  modport slave (
    input  i_policy_mode, i_cmd_valid, i_cmd_op, i_cmd_bank, i_cmd_row, i_cmd_col,
           i_cmd_dtype, i_ctrl_ready,
    output o_cmd_ready, o_cmd_valid, o_cmd_r_w, o_cmd_bank, o_cmd_row, o_cmd_col,
           o_cmd_auto_precharge, o_stat_hit, o_stat_conflict, o_stat_closed
  );

endinterface

// File: rtl/bank_row_tracker.sv
// Per-bank open-row state: classifies the addressed bank and computes its next locality count.
module bank_row_tracker #(
  parameter int unsigned NUM_BANKS = 8,
  parameter int unsigned ROW_BITS  = 16,
  parameter int unsigned CNT_BITS  = 2,
  parameter int unsigned CNT_INIT  = 2,
  localparam int unsigned BankBits = $clog2(NUM_BANKS)
) (
  input  logic                clk,
  input  logic                power_on_rst_n,
  input  logic [BankBits-1:0] bank_i,
  input  logic [ROW_BITS-1:0] row_i,
  input  logic                upd_en_i,
  input  logic                upd_open_i,
  output logic                hit_o,
  output logic                conflict_o,
  output logic                closed_o,
  output logic [CNT_BITS-1:0] cnt_next_o
);

  typedef struct packed {
    logic                open_valid;
    logic [ROW_BITS-1:0] open_row;
    logic [CNT_BITS-1:0] cnt;
  } row_state_t;

  localparam logic [CNT_BITS-1:0] CntMax = '1;
  localparam row_state_t ResetState = '{open_valid: 1'b0, open_row: '0,
                                        cnt: CNT_BITS'(CNT_INIT)};

  row_state_t state_q [NUM_BANKS];
  row_state_t cur;

  always_comb begin
    cur        = state_q[bank_i];
    hit_o      = cur.open_valid & (cur.open_row == row_i);
    conflict_o = cur.open_valid & ~hit_o;
    closed_o   = ~cur.open_valid;
    cnt_next_o = cur.cnt;
    if (hit_o && (cur.cnt != CntMax)) begin
      cnt_next_o = cur.cnt + CNT_BITS'(1);
    end else if (conflict_o && (cur.cnt != '0)) begin
      cnt_next_o = cur.cnt - CNT_BITS'(1);
    end
  end

  // State changes only at the edge, so back-to-back accepts see last cycle's write.
  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        state_q[i] <= ResetState;
      end
    end else if (upd_en_i) begin
      state_q[bank_i] <= '{open_valid: upd_open_i, open_row: row_i, cnt: cnt_next_o};
    end
  end

endmodule

// File: rtl/backend_row_policy_predictor.sv
// Backend command stage: per-bank row tracking, auto-precharge prediction under four row
// policies, a registered command stage towards Ctrl, and hit/conflict/closed statistics.
module backend_row_policy_predictor
  import backend_policy_pkg::*;
#(
  parameter int unsigned NUM_BANKS = 8,
  parameter int unsigned ROW_BITS  = 16,
  parameter int unsigned COL_BITS  = 4,
  parameter int unsigned LAST_COL  = 15,
  parameter int unsigned CNT_BITS  = 2,
  parameter int unsigned CNT_INIT  = 2,
  parameter int unsigned AP_THRESH = 2,
  parameter int unsigned STAT_BITS = 16
) (
  input logic                           clk,
  input logic                           power_on_rst_n,
  backend_row_policy_predictor_if.slave bus
);

  localparam int unsigned BankBits = $clog2(NUM_BANKS);
  localparam logic [STAT_BITS-1:0] StatMax = '1;

  if (LAST_COL >= 2 ** COL_BITS) begin : g_bad_last_col
    $error("LAST_COL does not fit in COL_BITS");
  end
  if (AP_THRESH > 2 ** CNT_BITS) begin : g_bad_ap_thresh
    $error("AP_THRESH exceeds counter range");
  end
  if ((NUM_BANKS < 2) || ((NUM_BANKS & (NUM_BANKS - 1)) != 0)) begin : g_bad_num_banks
    $error("NUM_BANKS must be a power of two >= 2");
  end

  logic                 ready;
  logic                 accept;
  logic                 hit, conflict, closed;
  logic [CNT_BITS-1:0]  cnt_next;
  logic                 last_col;
  logic                 ap;
  policy_mode_e         mode;
  data_type_e           dtype;

  logic                 cmd_valid_q;
  logic                 cmd_r_w_q;
  logic [BankBits-1:0]  cmd_bank_q;
  logic [ROW_BITS-1:0]  cmd_row_q;
  logic [COL_BITS-1:0]  cmd_col_q;
  logic                 cmd_ap_q;
  logic [STAT_BITS-1:0] stat_hit_q, stat_conflict_q, stat_closed_q;

  assign ready  = ~cmd_valid_q | bus.i_ctrl_ready;
  assign accept = bus.i_cmd_valid & ready;
  assign mode   = policy_mode_e'(bus.i_policy_mode);
  assign dtype  = data_type_e'(bus.i_cmd_dtype);

  bank_row_tracker #(
    .NUM_BANKS (NUM_BANKS),
    .ROW_BITS  (ROW_BITS),
    .CNT_BITS  (CNT_BITS),
    .CNT_INIT  (CNT_INIT)
  ) u_tracker (
    .clk            (clk),
    .power_on_rst_n (power_on_rst_n),
    .bank_i         (bus.i_cmd_bank),
    .row_i          (bus.i_cmd_row),
    .upd_en_i       (accept),
    .upd_open_i     (~ap),
    .hit_o          (hit),
    .conflict_o     (conflict),
    .closed_o       (closed),
    .cnt_next_o     (cnt_next)
  );

  // The adaptive policy uses the counter value after this access's own update.
  always_comb begin
    last_col = (bus.i_cmd_col == COL_BITS'(LAST_COL));
    ap       = 1'b0;
    case (mode)
      ModeOpen:     ap = 1'b0;
      ModeClose:    ap = 1'b1;
      ModeLastCol:  ap = last_col;
      ModeAdaptive: ap = last_col | (dtype_is_adaptive(dtype) & (32'(cnt_next) < AP_THRESH));
      default:      ap = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      cmd_valid_q <= 1'b0;
      cmd_r_w_q   <= 1'b0;
      cmd_bank_q  <= '0;
      cmd_row_q   <= '0;
      cmd_col_q   <= '0;
      cmd_ap_q    <= 1'b0;
    end else if (accept) begin
      cmd_valid_q <= 1'b1;
      cmd_r_w_q   <= bus.i_cmd_op;
      cmd_bank_q  <= bus.i_cmd_bank;
      cmd_row_q   <= bus.i_cmd_row;
      cmd_col_q   <= bus.i_cmd_col;
      cmd_ap_q    <= ap;
    end else if (bus.i_ctrl_ready) begin
      cmd_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      stat_hit_q      <= '0;
      stat_conflict_q <= '0;
      stat_closed_q   <= '0;
    end else if (accept) begin
      if (hit && (stat_hit_q != StatMax)) begin
        stat_hit_q <= stat_hit_q + STAT_BITS'(1);
      end
      if (conflict && (stat_conflict_q != StatMax)) begin
        stat_conflict_q <= stat_conflict_q + STAT_BITS'(1);
      end
      if (closed && (stat_closed_q != StatMax)) begin
        stat_closed_q <= stat_closed_q + STAT_BITS'(1);
      end
    end
  end

  assign bus.o_cmd_ready          = ready;
  assign bus.o_cmd_valid          = cmd_valid_q;
  assign bus.o_cmd_r_w            = cmd_r_w_q;
  assign bus.o_cmd_bank           = cmd_bank_q;
  assign bus.o_cmd_row            = cmd_row_q;
  assign bus.o_cmd_col            = cmd_col_q;
  assign bus.o_cmd_auto_precharge = cmd_ap_q;
  assign bus.o_stat_hit           = stat_hit_q;
  assign bus.o_stat_conflict      = stat_conflict_q;
  assign bus.o_stat_closed        = stat_closed_q;

endmodule

// File: tb/tb_backend_row_policy_predictor.sv
// Self-checking bench for backend_row_policy_predictor: directed scenarios plus random traffic
// compared against a behavioural row-policy model.
module tb_backend_row_policy_predictor;

  localparam int unsigned NB = 8;
  localparam int unsigned RB = 16;
  localparam int unsigned CB = 4;
  localparam int unsigned SB = 16;
  localparam int LastCol  = 15;
  localparam int CntMax   = 3;
  localparam int CntInit  = 2;
  localparam int ApThresh = 2;
  localparam int StatMax  = 65535;

  logic clk;
  logic power_on_rst_n;

  backend_row_policy_predictor_if #(
    .NUM_BANKS (NB), .ROW_BITS (RB), .COL_BITS (CB), .STAT_BITS (SB)
  ) bus ();

  backend_row_policy_predictor #(
    .NUM_BANKS (NB), .ROW_BITS (RB), .COL_BITS (CB), .LAST_COL (LastCol), .CNT_BITS (2),
    .CNT_INIT (CntInit), .AP_THRESH (ApThresh), .STAT_BITS (SB)
  ) dut (
    .clk            (clk),
    .power_on_rst_n (power_on_rst_n),
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit m_open [NB];
  int m_row  [NB];
  int m_cnt  [NB];
  int m_hit, m_conf, m_closed;
  bit e_valid, e_op, e_ap;
  int e_bank, e_row, e_col;
  bit e_ready;
  logic o_ready;
  int mode, dtype;

  function automatic logic [25:0] exp_vec();
    return {e_valid, e_op, 3'(e_bank), 16'(e_row), 4'(e_col), e_ap};
  endfunction

  function automatic logic [25:0] obs_vec();
    return {bus.o_cmd_valid, bus.o_cmd_r_w, bus.o_cmd_bank, bus.o_cmd_row, bus.o_cmd_col,
            bus.o_cmd_auto_precharge};
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      m_open[b] = 1'b0;
      m_row[b]  = 0;
      m_cnt[b]  = CntInit;
    end
    m_hit = 0; m_conf = 0; m_closed = 0;
    e_valid = 0; e_op = 0; e_ap = 0; e_bank = 0; e_row = 0; e_col = 0;
  endtask

  task automatic model_accept(input bit op, input int bank, input int row, input int col);
    bit is_hit, is_closed, ap;
    int c;
    is_closed = !m_open[bank];
    is_hit    = m_open[bank] && (m_row[bank] == row);
    c         = m_cnt[bank];
    if (is_hit) begin
      if (m_hit < StatMax) m_hit++;
      if (c < CntMax) c++;
    end else if (!is_closed) begin
      if (m_conf < StatMax) m_conf++;
      if (c > 0) c--;
    end else begin
      if (m_closed < StatMax) m_closed++;
    end
    m_cnt[bank] = c;
    case (mode)
      0:       ap = 1'b0;
      1:       ap = 1'b1;
      2:       ap = (col == LastCol);
      default: ap = (col == LastCol) || ((dtype >= 2) && (c < ApThresh));
    endcase
    m_open[bank] = !ap;
    m_row[bank]  = row;
    e_valid = 1; e_op = op; e_bank = bank; e_row = row; e_col = col; e_ap = ap;
  endtask

  // Called at a negedge; drives one cycle of inputs and returns at the next negedge.
  task automatic step(input bit v, input bit op, input int bank, input int row, input int col,
                      input bit rdy);
    bus.i_policy_mode = 2'(mode);
    bus.i_cmd_dtype   = 2'(dtype);
    bus.i_cmd_valid   = v;
    bus.i_cmd_op      = op;
    bus.i_cmd_bank    = 3'(bank);
    bus.i_cmd_row     = 16'(row);
    bus.i_cmd_col     = 4'(col);
    bus.i_ctrl_ready  = rdy;
    #1;
    o_ready = bus.o_cmd_ready;
    e_ready = !e_valid || rdy;
    if (v && e_ready) model_accept(op, bank, row, col);
    else if (rdy) e_valid = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++;
    if (obs_vec() !== 26'd0) begin
      errors++; $display("FAIL reset_out got %h want %h", obs_vec(), 26'd0);
    end
    checks++;
    if ({bus.o_stat_hit, bus.o_stat_conflict, bus.o_stat_closed} !== 48'd0) begin
      errors++; $display("FAIL reset_stats got %h/%h/%h want 0", bus.o_stat_hit,
                         bus.o_stat_conflict, bus.o_stat_closed);
    end
    checks++;
    if (bus.o_cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b want 1", bus.o_cmd_ready);
    end
  endtask

  task automatic test_last_col();
    mode = 2; dtype = 0;
    for (int c = 0; c < 16; c++) begin
      step(1'b1, c[0], 0, 5, c, 1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL last_col_out c=%0d got %h want %h", c, obs_vec(), exp_vec());
      end
      checks++;
      if (bus.o_cmd_auto_precharge !== (c == 15)) begin
        errors++; $display("FAIL last_col_ap c=%0d got %b want %b", c,
                           bus.o_cmd_auto_precharge, (c == 15));
      end
    end
    step(1'b0, 1'b0, 0, 0, 0, 1'b1);
    checks++;
    if (bus.o_cmd_valid !== 1'b0) begin
      errors++; $display("FAIL last_col_drain got %b want 0", bus.o_cmd_valid);
    end
    checks++;
    if ({bus.o_stat_closed, bus.o_stat_hit, bus.o_stat_conflict} !== {16'd1, 16'd15, 16'd0})
    begin
      errors++; $display("FAIL last_col_stats got c%0d h%0d x%0d want c1 h15 x0",
                         bus.o_stat_closed, bus.o_stat_hit, bus.o_stat_conflict);
    end
  endtask

  task automatic test_open_conflict();
    int base_conf, base_hit;
    mode = 0; dtype = 0;
    base_conf = m_conf; base_hit = m_hit;
    step(1'b1, 1'b1, 3, 7, 2, 1'b1);
    checks++;
    if (obs_vec() !== exp_vec() || bus.o_cmd_auto_precharge !== 1'b0) begin
      errors++; $display("FAIL open_first got %h want %h", obs_vec(), exp_vec());
    end
    step(1'b1, 1'b1, 3, 9, 2, 1'b1);
    checks++;
    if (bus.o_stat_conflict !== 16'(base_conf + 1) || bus.o_cmd_auto_precharge !== 1'b0) begin
      errors++; $display("FAIL open_conflict got x%0d ap%b want x%0d ap0",
                         bus.o_stat_conflict, bus.o_cmd_auto_precharge, base_conf + 1);
    end
    // Row 9 must now be the open row of bank 3.
    step(1'b1, 1'b0, 3, 9, 4, 1'b1);
    checks++;
    if (bus.o_stat_hit !== 16'(base_hit + 1)) begin
      errors++; $display("FAIL open_row9_hit got h%0d want h%0d", bus.o_stat_hit, base_hit + 1);
    end
  endtask

  task automatic run_seq(input string name, input int bank, input int d, input bit want0,
                         input bit want1, input bit want2);
    bit want [3];
    int rows [3];
    want[0] = want0; want[1] = want1; want[2] = want2;
    rows[0] = 4; rows[1] = 8; rows[2] = 4;
    mode = 3; dtype = d;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, bank, rows[i], 0, 1'b1);
      checks++;
      if (obs_vec() !== exp_vec() || bus.o_cmd_auto_precharge !== want[i]) begin
        errors++; $display("FAIL %s_%0d got %h want %h (ap %b)", name, i, obs_vec(), exp_vec(),
                           want[i]);
      end
    end
  endtask

  task automatic test_adaptive_kv();
    int base_conf, base_closed;
    base_conf = m_conf; base_closed = m_closed;
    run_seq("adapt_kv", 1, 2, 1'b0, 1'b1, 1'b1);
    checks++;
    if (bus.o_stat_conflict !== 16'(base_conf + 1) || bus.o_stat_closed !== 16'(base_closed + 2))
    begin
      errors++; $display("FAIL adapt_kv_stats got x%0d c%0d want x%0d c%0d", bus.o_stat_conflict,
                         bus.o_stat_closed, base_conf + 1, base_closed + 2);
    end
  endtask

  task automatic test_adaptive_weight();
    run_seq("adapt_wt", 2, 1, 1'b0, 1'b0, 1'b0);
    // Counter of bank 2 is now 0; a KV hit lifts it to 1, still below threshold.
    dtype = 2;
    step(1'b1, 1'b0, 2, 4, 0, 1'b1);
    checks++;
    if (bus.o_cmd_auto_precharge !== 1'b1 || obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL adapt_wt_warm got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_backpressure();
    int outs;
    mode = 0; dtype = 0; outs = 0;
    step(1'b1, 1'b1, 4, 'h11, 1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 4, 'h22, 2, 1'b0);
      checks++;
      if (o_ready !== 1'b0) begin
        errors++; $display("FAIL bp_ready_%0d got %b want 0", i, o_ready);
      end
      checks++;
      if (obs_vec() !== exp_vec() || bus.o_cmd_row !== 16'h11) begin
        errors++; $display("FAIL bp_hold_%0d got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    step(1'b1, 1'b0, 4, 'h22, 2, 1'b1);
    checks++;
    if (o_ready !== 1'b1 || obs_vec() !== exp_vec() || bus.o_cmd_row !== 16'h22) begin
      errors++; $display("FAIL bp_release got rdy%b %h want rdy1 %h", o_ready, obs_vec(),
                         exp_vec());
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 0, 0, 0, 1'b1);
      if (bus.o_cmd_valid === 1'b1) outs++;
    end
    checks++;
    if (outs != 0 || bus.o_stat_conflict !== 16'(m_conf)) begin
      errors++; $display("FAIL bp_dup got extra %0d x%0d want 0 x%0d", outs, bus.o_stat_conflict,
                         m_conf);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int n = 0; n < 400; n++) begin
      mode  = int'($urandom_range(0, 3));
      dtype = int'($urandom_range(0, 3));
      step($urandom_range(0, 3) != 0, 1'($urandom), int'($urandom_range(0, NB - 1)),
           int'($urandom_range(0, 3)),
           ($urandom_range(0, 3) == 0) ? LastCol : int'($urandom_range(0, 15)),
           $urandom_range(0, 3) != 0);
      checks++;
      if (o_ready !== e_ready || obs_vec() !== exp_vec()) begin
        errors++;
        if (bad++ < 10) $display("FAIL rand_%0d got rdy%b %h want rdy%b %h", n, o_ready,
                                 obs_vec(), e_ready, exp_vec());
      end
    end
    checks++;
    if (bus.o_stat_hit !== 16'(m_hit) || bus.o_stat_conflict !== 16'(m_conf) ||
        bus.o_stat_closed !== 16'(m_closed)) begin
      errors++; $display("FAIL rand_stats got h%0d x%0d c%0d want h%0d x%0d c%0d",
                         bus.o_stat_hit, bus.o_stat_conflict, bus.o_stat_closed, m_hit, m_conf,
                         m_closed);
    end
  endtask

  task automatic test_async_reset();
    mode = 0; dtype = 0;
    step(1'b1, 1'b1, 0, 'h55, 3, 1'b0);
    bus.i_cmd_valid = 1'b0;
    #3;
    power_on_rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.o_cmd_valid !== 1'b0 || obs_vec() !== 26'd0) begin
      errors++; $display("FAIL areset_out got %h want 0", obs_vec());
    end
    checks++;
    if ({bus.o_stat_hit, bus.o_stat_conflict, bus.o_stat_closed} !== 48'd0) begin
      errors++; $display("FAIL areset_stats got h%0d x%0d c%0d want 0", bus.o_stat_hit,
                         bus.o_stat_conflict, bus.o_stat_closed);
    end
    @(negedge clk);
    @(negedge clk);
    power_on_rst_n = 1'b1;
    mode = 3; dtype = 2;
    step(1'b1, 1'b1, 0, 5, 0, 1'b1);
    checks++;
    if (bus.o_stat_closed !== 16'd1 || bus.o_cmd_auto_precharge !== 1'b0) begin
      errors++; $display("FAIL areset_closed got c%0d ap%b want c1 ap0", bus.o_stat_closed,
                         bus.o_cmd_auto_precharge);
    end
    // Fresh counter (2) drops to 1 on this conflict, below threshold.
    step(1'b1, 1'b1, 0, 6, 0, 1'b1);
    checks++;
    if (bus.o_stat_conflict !== 16'd1 || bus.o_cmd_auto_precharge !== 1'b1 ||
        obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL areset_cnt got x%0d ap%b want x1 ap1", bus.o_stat_conflict,
                         bus.o_cmd_auto_precharge);
    end
  endtask

  initial begin
    power_on_rst_n    = 1'b0;
    mode = 0; dtype = 0;
    bus.i_policy_mode = 2'd0;
    bus.i_cmd_valid   = 1'b0;
    bus.i_cmd_op      = 1'b0;
    bus.i_cmd_bank    = '0;
    bus.i_cmd_row     = '0;
    bus.i_cmd_col     = '0;
    bus.i_cmd_dtype   = 2'd0;
    bus.i_ctrl_ready  = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    power_on_rst_n = 1'b1;
    test_last_col();
    test_open_conflict();
    test_adaptive_kv();
    test_adaptive_weight();
    test_backpressure();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
